mem_responder: RTL and testbench

//  Target side of the core's memory port. Decodes core_address/core_we/core_byte_enable and returns core_data_in.

---
 rtl/mem_responder_if.sv | 24 ++
 rtl/mem_responder.sv | 134 +++++++++++++
 tb/tb_mem_responder.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_responder_if.sv
// Core memory port plus TX byte stream and sticky status flags.
// The core side (or a bench) uses master; the responder uses slave.
interface mem_responder_if;
   logic [31:0] core_address;
   logic [31:0] core_data_out;
   logic [3:0]  core_byte_enable;
   logic        core_we;
   logic [31:0] core_data_in;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready;
   logic        halted;
   logic        bus_error;

   modport master (
      output core_address, core_data_out, core_byte_enable, core_we, tx_ready,
      input  core_data_in, tx_data, tx_valid, halted, bus_error
   );

   modport slave (
      input  core_address, core_data_out, core_byte_enable, core_we, tx_ready,
      output core_data_in, tx_data, tx_valid, halted, bus_error
   );
endinterface

// File: rtl/mem_responder.sv
// Memory-port target: byte-writable RAM with combinational read, plus an MMIO
// window holding a TX FIFO, status, a free-running cycle counter and a halt latch.
module mem_responder #(
   parameter int          MEM_WORDS  = 4096,
   parameter              INIT_FILE  = "",
   parameter int          FIFO_DEPTH = 8,
   parameter logic [31:0] MMIO_BASE  = 32'h8000_0000
) (
   input  logic             clk,
   input  logic             reset,
   mem_responder_if.slave   bus
);
   localparam int AW = $clog2(MEM_WORDS);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam logic [PW:0] DEPTH_C = (PW + 1)'(FIFO_DEPTH);

   logic [31:0]   r_mem [MEM_WORDS];
   logic [7:0]    r_fifo [FIFO_DEPTH];
   logic [PW-1:0] r_rd_ptr;
   logic [PW-1:0] r_wr_ptr;
   logic [PW:0]   r_count;
   logic          r_overflow;
   logic          r_halted;
   logic          r_bus_error;
   logic [31:0]   r_cycle;

   logic          w_ram_sel;
   logic          w_mmio_sel;
   logic [1:0]    w_reg;
   logic [AW-1:0] w_idx;
   logic          w_wr;
   logic          w_be_any;
   logic [3:0]    w_lane_we;
   logic          w_full;
   logic          w_empty;
   logic          w_pop;
   logic          w_push_req;
   logic          w_push_ok;
   logic          w_ovf_set;
   logic          w_ovf_clr;
   logic          w_cyc_wr;
   logic          w_halt_wr;
   logic          w_unmapped_wr;
   logic [31:0]   w_status;
   logic [31:0]   w_rdata;
   logic          w_unused_addr;

   // Address decode; the low two address bits never select anything.
   assign w_ram_sel     = (bus.core_address[31:AW+2] == '0);
   assign w_mmio_sel    = (bus.core_address[31:4] == MMIO_BASE[31:4]);
   assign w_reg         = bus.core_address[3:2];
   assign w_idx         = bus.core_address[AW+1:2];
   assign w_unused_addr = ^bus.core_address[1:0];

   // Writes on the reset edge are dropped everywhere, not only in the MMIO block.
   assign w_wr     = bus.core_we && !reset;
   assign w_be_any = |bus.core_byte_enable;

   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_lane
         assign w_lane_we[gi] = w_wr && w_ram_sel && bus.core_byte_enable[gi];
      end
   endgenerate

   assign w_full        = (r_count == DEPTH_C);
   assign w_empty       = (r_count == '0);
   assign w_pop         = !w_empty && bus.tx_ready;
   assign w_push_req    = w_wr && w_mmio_sel && (w_reg == 2'd0) && bus.core_byte_enable[0];
   assign w_push_ok     = w_push_req && (!w_full || w_pop);
   assign w_ovf_set     = w_push_req && w_full && !w_pop;
   assign w_ovf_clr     = w_wr && w_mmio_sel && (w_reg == 2'd1) && w_be_any && bus.core_data_out[2];
   assign w_cyc_wr      = w_wr && w_mmio_sel && (w_reg == 2'd2) && w_be_any;
   assign w_halt_wr     = w_wr && w_mmio_sel && (w_reg == 2'd3) && w_be_any;
   assign w_unmapped_wr = w_wr && !w_ram_sel && !w_mmio_sel && w_be_any;

   always_ff @(posedge clk) begin
      for (int i = 0; i < 4; i++) begin
         if (w_lane_we[i]) r_mem[w_idx][i*8 +: 8] <= bus.core_data_out[i*8 +: 8];
      end
   end

   always_ff @(posedge clk) begin
      if (w_push_ok) r_fifo[r_wr_ptr] <= bus.core_data_out[7:0];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_rd_ptr    <= '0;
         r_wr_ptr    <= '0;
         r_count     <= '0;
         r_overflow  <= 1'b0;
         r_halted    <= 1'b0;
         r_bus_error <= 1'b0;
         r_cycle     <= '0;
      end else begin
         if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)     r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_push_ok, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
         // A same-edge overflow beats the W1C clear.
         if (w_ovf_set)      r_overflow <= 1'b1;
         else if (w_ovf_clr) r_overflow <= 1'b0;
         if (w_halt_wr)     r_halted    <= 1'b1;
         if (w_unmapped_wr) r_bus_error <= 1'b1;
         if (w_cyc_wr)       r_cycle <= '0;
         else if (!r_halted) r_cycle <= r_cycle + 32'd1;
      end
   end

   assign w_status = {16'b0, 8'(r_count), 3'b0, r_bus_error, r_halted, r_overflow, w_full, w_empty};

   always_comb begin
      w_rdata = '0;
      if (w_ram_sel) begin
         w_rdata = r_mem[w_idx];
      end else if (w_mmio_sel) begin
         case (w_reg)
            2'd1:    w_rdata = w_status;
            2'd2:    w_rdata = r_cycle;
            2'd3:    w_rdata = {31'b0, r_halted};
            default: w_rdata = '0;
         endcase
      end
   end

   assign bus.core_data_in = w_rdata;
   assign bus.tx_data      = r_fifo[r_rd_ptr];
   assign bus.tx_valid     = !w_empty;
   assign bus.halted       = r_halted;
   assign bus.bus_error    = r_bus_error;
endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: directed vector table, hand sequences for FIFO,
// counter, halt and reset corners, then random traffic against a queue-based model.
module tb_mem_responder;
   localparam int MEM_BYTES = 4096 * 4;
   localparam logic [31:0] A_TX  = 32'h8000_0000;
   localparam logic [31:0] A_ST  = 32'h8000_0004;
   localparam logic [31:0] A_CYC = 32'h8000_0008;
   localparam logic [31:0] A_HLT = 32'h8000_000C;

   logic clk;
   logic reset;
   mem_responder_if bus();

   mem_responder dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: byte-lane RAM with known-mask, FIFO as a queue.
   logic [31:0] m_mem [4096];
   logic [3:0]  m_mv  [4096];
   logic [7:0]  m_q[$];
   logic        m_ovf;
   logic        m_halt;
   logic        m_berr;
   logic [31:0] m_cyc;

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  be;
      logic        chk;
      logic [31:0] exp;
   } vec_t;
   vec_t vecs[14];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] model_read(input logic [31:0] addr, output logic known);
      int idx;
      known = 1'b1;
      if (addr < MEM_BYTES) begin
         idx   = int'(addr[13:2]);
         known = (m_mv[idx] == 4'hF);
         return m_mem[idx];
      end else if (addr[31:4] == A_TX[31:4]) begin
         case (addr[3:2])
            2'd1:    return {16'b0, 8'(m_q.size()), 3'b0, m_berr, m_halt, m_ovf,
                             m_q.size() == 8, m_q.size() == 0};
            2'd2:    return m_cyc;
            2'd3:    return {31'b0, m_halt};
            default: return 32'h0;
         endcase
      end
      return 32'h0;
   endfunction

   task automatic check_outputs(input logic [31:0] addr);
      logic [31:0] exp;
      logic        known;
      exp = model_read(addr, known);
      if (known) check("rdata", bus.core_data_in, exp);
      check("tx_valid", {31'b0, bus.tx_valid}, {31'b0, m_q.size() != 0});
      if (m_q.size() != 0) check("tx_data", {24'b0, bus.tx_data}, {24'b0, m_q[0]});
      check("halted", {31'b0, bus.halted}, {31'b0, m_halt});
      check("bus_error", {31'b0, bus.bus_error}, {31'b0, m_berr});
   endtask

   task automatic model_edge(input logic rst, input logic we, input logic [31:0] addr,
                             input logic [31:0] data, input logic [3:0] be, input logic ready);
      logic is_ram, is_mmio, popped, full, push;
      int   idx;
      if (rst) begin
         m_q.delete();
         m_ovf = 0; m_halt = 0; m_berr = 0; m_cyc = 0;
         return;
      end
      is_ram  = addr < MEM_BYTES;
      is_mmio = addr[31:4] == A_TX[31:4];
      popped  = (m_q.size() != 0) && ready;
      full    = m_q.size() == 8;
      push    = we && is_mmio && addr[3:2] == 2'd0 && be[0];
      if (we && is_mmio && addr[3:2] == 2'd2 && be != 0) m_cyc = 0;
      else if (!m_halt) m_cyc = m_cyc + 1;
      if (we && is_mmio && addr[3:2] == 2'd3 && be != 0) m_halt = 1;
      if (push && full && !popped) m_ovf = 1;
      else if (we && is_mmio && addr[3:2] == 2'd1 && be != 0 && data[2]) m_ovf = 0;
      if (popped) void'(m_q.pop_front());
      if (push && (!full || popped)) m_q.push_back(data[7:0]);
      if (we && !is_ram && !is_mmio && be != 0) m_berr = 1;
      if (we && is_ram) begin
         idx = int'(addr[13:2]);
         for (int l = 0; l < 4; l++) begin
            if (be[l]) begin
               m_mem[idx][l*8 +: 8] = data[l*8 +: 8];
               m_mv[idx][l] = 1'b1;
            end
         end
      end
   endtask

   // One clock: drive at negedge, check before the edge, advance model and DUT.
   task automatic step(input logic rst, input logic we, input logic [31:0] addr,
                       input logic [31:0] data, input logic [3:0] be, input logic ready);
      reset                = rst;
      bus.core_we          = we;
      bus.core_address     = addr;
      bus.core_data_out    = data;
      bus.core_byte_enable = be;
      bus.tx_ready         = ready;
      #1;
      if (!rst) check_outputs(addr);
      model_edge(rst, we, addr, data, be, ready);
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) step(0, 0, A_ST, 0, 0, 0);
   endtask

   task automatic peek(input string name, input logic [31:0] addr, input logic [31:0] exp);
      reset                = 1'b0;
      bus.core_we          = 1'b0;
      bus.core_byte_enable = 4'h0;
      bus.core_address     = addr;
      #1;
      check(name, bus.core_data_in, exp);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] a, d;
      logic [3:0]  be;
      int          op;

      for (int i = 0; i < 4096; i++) m_mv[i] = 4'h0;
      reset = 1; bus.core_we = 0; bus.core_address = 0; bus.core_data_out = 0;
      bus.core_byte_enable = 0; bus.tx_ready = 0;
      @(negedge clk);

      // Reset state, cycle counter and halt
      step(1, 0, A_ST, 0, 0, 0);
      peek("reset_status", A_ST, 32'h0000_0001);
      check("reset_tx_valid", {31'b0, bus.tx_valid}, 32'h0);
      peek("reset_cycle", A_CYC, 32'h0);
      idle(10);
      peek("cycle_after_10", A_CYC, 32'd10);
      step(0, 1, A_CYC, 32'h1234_5678, 4'hF, 0);
      idle(1);
      peek("cycle_after_clear", A_CYC, 32'd1);
      step(0, 1, A_HLT, 32'h1, 4'hF, 0);
      check("halted_flag", {31'b0, bus.halted}, 32'h1);
      peek("halt_reg", A_HLT, 32'h1);
      idle(5);
      peek("cycle_frozen", A_CYC, 32'd2);
      $display("seq cycle/halt done");

      // Directed vector table
      step(1, 0, A_ST, 0, 0, 0);
      vecs[0]  = '{1'b1, 32'h10,        32'hAABB_CCDD, 4'hF, 1'b0, 32'h0};
      vecs[1]  = '{1'b1, 32'h10,        32'h0011_0000, 4'h4, 1'b0, 32'h0};
      vecs[2]  = '{1'b0, 32'h10,        32'h0,         4'h0, 1'b1, 32'hAA11_CCDD};
      vecs[3]  = '{1'b0, 32'h12,        32'h0,         4'h0, 1'b1, 32'hAA11_CCDD};
      vecs[4]  = '{1'b1, 32'h10,        32'hFFFF_FFFF, 4'h0, 1'b0, 32'h0};
      vecs[5]  = '{1'b0, 32'h13,        32'h0,         4'h0, 1'b1, 32'hAA11_CCDD};
      vecs[6]  = '{1'b1, 32'h0,         32'h1234_5678, 4'hF, 1'b0, 32'h0};
      vecs[7]  = '{1'b1, 32'h4000_0000, 32'hDEAD_BEEF, 4'hF, 1'b0, 32'h0};
      vecs[8]  = '{1'b0, 32'h0,         32'h0,         4'h0, 1'b1, 32'h1234_5678};
      vecs[9]  = '{1'b0, 32'h4000_0000, 32'h0,         4'h0, 1'b1, 32'h0};
      vecs[10] = '{1'b0, A_TX,          32'h0,         4'h0, 1'b1, 32'h0};
      vecs[11] = '{1'b0, A_HLT,         32'h0,         4'h0, 1'b1, 32'h0};
      vecs[12] = '{1'b0, A_ST,          32'h0,         4'h0, 1'b1, 32'h0000_0011};
      vecs[13] = '{1'b0, 32'h8000_0010, 32'h0,         4'h0, 1'b1, 32'h0};
      for (int i = 0; i < 14; i++) begin
         reset = 0; bus.core_we = vecs[i].we; bus.core_address = vecs[i].addr;
         bus.core_data_out = vecs[i].data; bus.core_byte_enable = vecs[i].be;
         #1;
         if (vecs[i].chk) check($sformatf("vec%0d", i), bus.core_data_in, vecs[i].exp);
         $display("vec %0d we=%0b addr=%h data=%h be=%h rdata=%h", i, vecs[i].we,
                  vecs[i].addr, vecs[i].data, vecs[i].be, bus.core_data_in);
         step(0, vecs[i].we, vecs[i].addr, vecs[i].data, vecs[i].be, 0);
      end
      check("bus_error_set", {31'b0, bus.bus_error}, 32'h1);

      // FIFO fill, overflow, W1C, full-with-pop, drain order, empty-push latency
      step(1, 0, A_ST, 0, 0, 0);
      for (int i = 0; i < 8; i++) step(0, 1, A_TX, 32'h41 + i, 4'h1, 0);
      peek("fifo_full_status", A_ST, 32'h0000_0802);
      step(0, 1, A_TX, 32'h4A, 4'h1, 0);
      peek("fifo_overflow_status", A_ST, 32'h0000_0806);
      check("fifo_head_hold", {24'b0, bus.tx_data}, 32'h41);
      step(0, 1, A_ST, 32'h4, 4'hF, 0);
      peek("fifo_w1c_status", A_ST, 32'h0000_0802);
      step(0, 1, A_TX, 32'h49, 4'h1, 1);
      peek("fifo_full_pop_status", A_ST, 32'h0000_0802);
      for (int i = 0; i < 8; i++) begin
         bus.core_we = 0; #1;
         check($sformatf("drain_valid%0d", i), {31'b0, bus.tx_valid}, 32'h1);
         check($sformatf("drain_data%0d", i), {24'b0, bus.tx_data}, 32'h42 + i);
         step(0, 0, A_ST, 0, 0, 1);
      end
      peek("fifo_empty_status", A_ST, 32'h0000_0001);
      check("drained_valid", {31'b0, bus.tx_valid}, 32'h0);
      step(0, 1, A_TX, 32'h55, 4'h1, 0);
      check("push_latency_valid", {31'b0, bus.tx_valid}, 32'h1);
      check("push_latency_data", {24'b0, bus.tx_data}, 32'h55);
      $display("seq fifo done");

      // Random traffic against the model
      step(1, 0, A_ST, 0, 0, 0);
      for (int w = 0; w < 64; w++) step(0, 1, 32'(w * 4), $urandom, 4'hF, 0);
      for (int t = 0; t < 800; t++) begin
         op = $urandom_range(0, 11);
         a  = 32'($urandom_range(0, 255));
         d  = $urandom;
         be = 4'($urandom_range(0, 15));
         case (op)
            0, 1, 2: step(0, 1, a, d, be, 1'($urandom_range(0, 1)));
            3, 4:    step(0, 0, a, d, be, 1'($urandom_range(0, 1)));
            5, 6:    step(0, 1, A_TX, d, be, 1'($urandom_range(0, 3) == 0));
            7:       step(0, 1, A_ST, d, be, 1'($urandom_range(0, 1)));
            8:       step(0, 0, A_ST, d, be, 1'($urandom_range(0, 1)));
            9:       step(0, ($urandom_range(0, 7) == 0), A_CYC, d, be, 1'($urandom_range(0, 1)));
            10:      step(0, 1, 32'h4000_0000 | a, d, be, 1'($urandom_range(0, 1)));
            default: step(0, 0, A_CYC, d, be, 1'($urandom_range(0, 1)));
         endcase
      end
      $display("seq random done");

      // Reset mid-transfer with 3 entries queued; write on reset edge dropped
      step(1, 0, A_ST, 0, 0, 0);
      step(0, 1, 32'h14, 32'hCAFE_F00D, 4'hF, 0);
      step(0, 1, A_TX, 32'h11, 4'h1, 0);
      step(0, 1, A_TX, 32'h22, 4'h1, 0);
      step(0, 1, A_TX, 32'h33, 4'h1, 1);
      step(0, 1, A_TX, 32'h44, 4'h1, 0);
      peek("pre_reset_status", A_ST, 32'h0000_0300);
      step(1, 1, 32'h14, 32'h0BAD_0BAD, 4'hF, 1);
      check("post_reset_valid", {31'b0, bus.tx_valid}, 32'h0);
      peek("post_reset_status", A_ST, 32'h0000_0001);
      peek("post_reset_ram", 32'h14, 32'hCAFE_F00D);
      $display("seq reset-mid-transfer done");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
